// File: rtl/beat_timing_gen.sv
// Machine-cycle beat generator (w1/w2/w3) with panel start and controller short/long/stop handling.
// One-cycle beat update on t3; no backpressure, controller requests take effect at the next edge.
module beat_timing_gen #(
    parameter int CNT_W = 16
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        B_W1 = 3'b001,
        B_W2 = 3'b010,
        B_W3 = 3'b100
    } beat_t;

    state_t           r_state;
    beat_t            r_beat;
    logic             r_running;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q1;
    logic             r_q2;
    logic             r_q3;

    beat_t            w_next_beat;
    logic             w_start;
    logic             w_halt;

    // Three-flop synchroniser; the third flop only serves edge detection.
    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            r_q1 <= 1'b0;
            r_q2 <= 1'b0;
            r_q3 <= 1'b0;
        end else begin
            r_q1 <= qd;
            r_q2 <= r_q1;
            r_q3 <= r_q2;
        end
    end

    assign w_start = r_q2 & ~r_q3;

    always_comb begin
        w_next_beat = B_W1;
        case (r_beat)
            B_W1:    w_next_beat = short ? B_W1 : B_W2;
            B_W2:    w_next_beat = long  ? B_W3 : B_W1;
            default: w_next_beat = B_W1;
        endcase
    end

    // Halting still lets the current advance happen, so a long+stop parks in w3.
    assign w_halt = stop | (step_mode & (w_next_beat == B_W1));

    always_ff @(posedge t3 or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_beat    <= B_W1;
            r_running <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_beat <= w_next_beat;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_halt) begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign w1        = r_beat[0];
    assign w2        = r_beat[1];
    assign w3        = r_beat[2];
    assign running   = r_running;
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed, table-driven bench for beat_timing_gen with a 4-bit counter.
module tb_beat_timing_gen;

    localparam int CNT_W = 4;

    logic             t3;
    logic             clr;
    logic             qd;
    logic             step_mode;
    logic             short;
    logic             long;
    logic             stop;
    logic             w1;
    logic             w2;
    logic             w3;
    logic             running;
    logic [CNT_W-1:0] cycle_cnt;

    int n_chk;
    int n_pass;

    typedef struct packed {
        logic             qd;
        logic             stp;
        logic             sh;
        logic             lg;
        logic             sp;
        logic [2:0]       w;
        logic             run;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    beat_timing_gen #(.CNT_W(CNT_W)) dut (
        .t3        (t3),
        .clr       (clr),
        .qd        (qd),
        .step_mode (step_mode),
        .short     (short),
        .long      (long),
        .stop      (stop),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .running   (running),
        .cycle_cnt (cycle_cnt)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    function automatic vec_t mk(input logic q, input logic st, input logic s, input logic l,
                                input logic p, input logic [2:0] w, input logic r, input int c);
        vec_t v;
        v.qd  = q;
        v.stp = st;
        v.sh  = s;
        v.lg  = l;
        v.sp  = p;
        v.w   = w;
        v.run = r;
        v.cnt = c[CNT_W-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [2:0] w_exp,
                       input logic run_exp, input logic [CNT_W-1:0] cnt_exp);
        n_chk++;
        if ({w1, w2, w3} === w_exp) n_pass++;
        else $display("FAIL %s[%0d] w: got %b expected %b", name, idx, {w1, w2, w3}, w_exp);
        n_chk++;
        if (running === run_exp) n_pass++;
        else $display("FAIL %s[%0d] running: got %b expected %b", name, idx, running, run_exp);
        n_chk++;
        if (cycle_cnt === cnt_exp) n_pass++;
        else $display("FAIL %s[%0d] cnt: got %0d expected %0d", name, idx, cycle_cnt, cnt_exp);
    endtask

    task automatic tick();
        @(posedge t3);
        #1;
    endtask

    task automatic drive(input logic q, input logic st, input logic s, input logic l, input logic p);
        qd        = q;
        step_mode = st;
        short     = s;
        long      = l;
        stop      = p;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        clr    = 1'b0;
        drive(0, 0, 0, 0, 0);

        //     qd st sh lg sp   w     run cnt
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b010, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b100, 1, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b010, 1, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b100, 1, 4));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'b010, 1, 5));
        vecs.push_back(mk(0, 0, 0, 1, 0, 3'b001, 1, 6));
        vecs.push_back(mk(0, 0, 1, 1, 0, 3'b100, 1, 7));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3'b100, 1, 8));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3'b100, 1, 9));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3'b100, 1, 10));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b010, 1, 11));
        vecs.push_back(mk(0, 0, 1, 0, 0, 3'b100, 1, 12));
        vecs.push_back(mk(0, 0, 1, 0, 1, 3'b100, 0, 13));
        for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 1, 1, 1, 1, 3'b100, 0, 13));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 13));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 0, 13));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b100, 1, 13));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b010, 1, 14));
        vecs.push_back(mk(0, 0, 0, 1, 1, 3'b001, 0, 15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b001, 0, 15));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b001, 0, 15));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b001, 0, 15));
        vecs.push_back(mk(1, 0, 0, 0, 0, 3'b001, 1, 15));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b100, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 3'b010, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 1, 2));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b010, 1, 3));
        vecs.push_back(mk(1, 1, 0, 1, 0, 3'b001, 1, 4));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 5));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 5));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 0, 0, 3'b100, 0, 5));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 5));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 0, 5));
        vecs.push_back(mk(1, 1, 0, 0, 0, 3'b100, 1, 5));
        vecs.push_back(mk(0, 1, 1, 0, 0, 3'b100, 0, 6));

        #12;
        chk("reset", 0, 3'b100, 1'b0, 4'd0);
        clr = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].qd, vecs[i].stp, vecs[i].sh, vecs[i].lg, vecs[i].sp);
            tick();
            chk("vec", i, vecs[i].w, vecs[i].run, vecs[i].cnt);
        end

        // Flush the synchroniser, then press start again for the wrap run.
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        qd = 1'b1;
        tick();
        tick();
        tick();
        chk("restart", 0, 3'b100, 1'b1, 4'd6);
        qd = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("wrap", i, (i % 2 == 1) ? 3'b010 : 3'b100, 1'b1, 4'((6 + i) % 16));
        end

        tick();
        chk("pre_w3", 0, 3'b010, 1'b1, 4'd7);
        long = 1'b1;
        tick();
        chk("pre_w3", 1, 3'b001, 1'b1, 4'd8);
        long = 1'b0;

        // Reset lands mid-cycle, well away from any t3 rising edge.
        #2;
        clr = 1'b0;
        #1;
        chk("async_rst", 0, 3'b100, 1'b0, 4'd0);
        #3;
        clr = 1'b1;
        tick();
        chk("post_rst", 0, 3'b100, 1'b0, 4'd0);
        tick();
        chk("post_rst", 1, 3'b100, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/beat_timing_gen.md
Name: beat_timing_gen

Overview:
Generates the machine-cycle beat signals w1/w2/w3 that the hardwired controller consumes. It also honours the controller's short/long/stop requests, which are fed back to this block. Start/run/halt sequencing is driven by the panel start button qd, with optional single-instruction stepping. The block sits between the panel/clock source and the controller, and is clocked by the t3 phase.

Parameters:
CNT_W, 16, width of the beat counter cycle_cnt

Ports:
t3  input  1  clock; all state updates on rising edge
clr  input  1  asynchronous active-low reset
qd  input  1  panel start button, asynchronous level; rising edge requests run
step_mode  input  1  1 = halt after each complete instruction (return to w1)
short  input  1  from controller, valid during w1: next beat is w1 again
long  input  1  from controller, valid during w2: insert w3
stop  input  1  from controller: halt after the current beat completes
w1  output  1  beat 1, one-hot with w2/w3
w2  output  1  beat 2
w3  output  1  beat 3
running  output  1  1 while the FSM is in RUN
cycle_cnt  output  CNT_W  count of beat advances since reset; wraps

Behaviour:
- Reset (clr=0, async, immediate at any time, including mid-cycle):
  - beat = w1 (w1=1, w2=0, w3=0); FSM = IDLE; running=0; cycle_cnt=0; qd synchroniser flops = 0.
- Exactly one of w1/w2/w3 is 1 at all times; all are registered outputs.
- qd synchroniser: q1<=qd, q2<=q1, q3<=q2. start = q2 & ~q3 (combinational).
  - qd high before edge k gives q2=1 after edge k+1. FSM enters RUN at edge k+2. First beat advance is at edge k+3.
  - start while in RUN is ignored. Holding qd high produces no further starts.
- FSM states: IDLE, RUN.
  - IDLE: beat held, cycle_cnt held, running=0. start -> RUN at the next edge.
  - RUN: running=1. Beat advances every edge per the beat rules. cycle_cnt += 1 every advance, mod 2^CNT_W.
- Beat rules in RUN (next beat):
  - w1: short -> w1; else w2. long is ignored in w1.
  - w2: long -> w3; else w1. short is ignored in w2.
  - w3: -> w1. short and long are ignored.
- Halt rules in RUN, evaluated at the same edge as the beat advance:
  - stop=1 -> beat advances normally, then FSM -> IDLE (running=0 after that edge).
  - step_mode=1 and next beat is w1 -> FSM -> IDLE after the advance.
  - Both halt conditions true -> single transition to IDLE; no difference in outcome.
- Combined controls:
  - short and stop together in w1 -> beat stays w1; FSM -> IDLE.
  - long and stop together in w2 -> beat goes to w3; FSM -> IDLE, so it halts sitting in w3. The next start resumes from w3, then goes to w1.
- Any control inputs during IDLE have no effect.
- cycle_cnt wraps from all-ones to 0 with no flag.
- Inputs short/long/stop/step_mode are sampled synchronously. They must be stable around the t3 rising edge; they are not synchronised.

Test Plan:
- Reset then start: clr pulse low; check w=100, running=0, cnt=0. Raise qd before edge 0 -> running=1 after edge 2; w=010 after edge 3; cnt=1.
- Normal and long cycles: RUN with short=long=stop=0 -> w sequence 100,010,100,010; cnt +1 each edge. Assert long in w2 -> 010,001,100. long asserted in w1 or w3 has no effect.
- Short cycle and stop: short=1 in w1 for 3 edges -> w stays 100, cnt +3. short=1 & stop=1 in w1 -> w=100, running=0 next edge; cnt frozen afterwards for 5 edges. Second qd edge -> resumes.
- Step mode: step_mode=1, start -> 100->010->100 then running=0. long=1 at w2 -> 010->001->100, then running=0. qd held high -> no restart until released and re-pressed.
- Wrap and async reset: CNT_W=4, run 16 advances -> cnt returns to 0 with w sequence intact. Drop clr during w3 between edges -> w=100, running=0, cnt=0 immediately, without waiting for a t3 edge.
